// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-ported general-purpose register file.
//   NUM_RD combinational read ports with same-cycle write bypass, two write
//   lanes (lane 1 wins on a same-index collision), and a per-register
//   pending-write scoreboard that decode uses for RAW hazard detection.
// Ports:
//   clk, Reset            clock, synchronous active-high reset
//   rd_addr / rd_data     packed read indices / data, port k at slice k
//   rd_busy               per-port pending-write flag (combinational)
//   wr0_* / wr1_*         write lanes (enable, index, data)
//   iss_en / iss_addr     destination of the instruction issuing this cycle
//   wr_count              committed register writes since reset (wraps)

// Single read port: zero-register override, bypass from the write lanes,
// then stored value. The busy flag is masked by a same-cycle write because
// that write's data is already forwarded.
module gpr_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]                      addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs,
  input  logic [(1<<ADDR_W)-1:0]                 busy,
  input  logic                                   wr0_eff,
  input  logic [ADDR_W-1:0]                      wr0_addr,
  input  logic [DATA_W-1:0]                      wr0_data,
  input  logic                                   wr1_eff,
  input  logic [ADDR_W-1:0]                      wr1_addr,
  input  logic [DATA_W-1:0]                      wr1_data,
  output logic [DATA_W-1:0]                      data,
  output logic                                   pend
);
  localparam logic ZR = (ZERO_REG != 0);

  logic is_zero, hit0, hit1;

  assign is_zero = ZR && (addr == '0);
  assign hit1    = wr1_eff && (wr1_addr == addr);
  assign hit0    = wr0_eff && (wr0_addr == addr);

  always_comb begin
    if (is_zero)   data = '0;
    else if (hit1) data = wr1_data;
    else if (hit0) data = wr0_data;
    else           data = regs[addr];
  end

  assign pend = busy[addr] && !hit0 && !hit1 && !is_zero;
endmodule

module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [31:0]                wr_count
);
  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic                         wr0_eff, wr1_eff, iss_eff;
  logic [1:0]                   inc;

  // Writes/issues to r0 are dropped entirely when r0 is hardwired.
  assign wr0_eff = wr0_en && !(ZR && (wr0_addr == '0));
  assign wr1_eff = wr1_en && !(ZR && (wr1_addr == '0));
  assign iss_eff = iss_en && !(ZR && (iss_addr == '0));

  // A same-index collision commits only one value, so it counts once.
  always_comb begin
    if (wr0_eff && wr1_eff && (wr0_addr == wr1_addr)) inc = 2'd1;
    else inc = {1'b0, wr0_eff} + {1'b0, wr1_eff};
  end

  // Issue is applied after the clears: a same-cycle issue is the younger
  // producer and must keep the register busy.
  always_comb begin
    busy_nxt = busy;
    if (wr0_eff) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_eff) busy_nxt[wr1_addr] = 1'b0;
    if (iss_eff) busy_nxt[iss_addr] = 1'b1;
    if (ZR)      busy_nxt[0]        = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      regs     <= '0;
      busy     <= '0;
      wr_count <= '0;
    end else begin
      // Lane 1 assigned last so it wins a collision.
      if (wr0_eff) regs[wr0_addr] <= wr0_data;
      if (wr1_eff) regs[wr1_addr] <= wr1_data;
      busy     <= busy_nxt;
      wr_count <= wr_count + {30'd0, inc};
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    gpr_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .wr0_eff (wr0_eff),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_eff (wr1_eff),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .data    (rd_data[k*DATA_W +: DATA_W]),
      .pend    (rd_busy[k])
    );
  end

`ifndef SYNTHESIS
  // Retire trace, one line per effective write lane.
  always @(posedge clk) begin
    if (!Reset) begin
      if (wr0_eff) $display("@%0t: $%0d <= %h", $time, wr0_addr, wr0_data);
      if (wr1_eff) $display("@%0t: $%0d <= %h", $time, wr1_addr, wr1_data);
    end
  end
`endif
endmodule

// File: tb/tb_gpr_file_mp.sv
module tb_gpr_file_mp;
  localparam int DW = 32, AW = 5, NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en, wr1_en, iss_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [31:0]       wr_count;

  gpr_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .wr_count(wr_count)
  );

  int checks = 0, errors = 0;

  // Architectural reference: register contents, outstanding producers,
  // committed-write tally.
  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];
  logic [31:0]   m_cnt;

  function automatic bit eff0(); return wr0_en && wr0_addr != 0; endfunction
  function automatic bit eff1(); return wr1_en && wr1_addr != 0; endfunction

  function automatic logic [DW-1:0] exp_data(int k);
    int a = int'(rd_addr[k*AW +: AW]);
    if (a == 0) return '0;
    if (eff1() && int'(wr1_addr) == a) return wr1_data;
    if (eff0() && int'(wr0_addr) == a) return wr0_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int k);
    int a = int'(rd_addr[k*AW +: AW]);
    if (a == 0) return 1'b0;
    if (eff0() && int'(wr0_addr) == a) return 1'b0;
    if (eff1() && int'(wr1_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle();
    Reset = 0; wr0_en = 0; wr1_en = 0; iss_en = 0;
  endtask

  task automatic set_rd(int k, int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  // Commit the current inputs to the model, then clock the DUT.
  task automatic step();
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_cnt = '0;
    end else begin
      bit e0 = eff0(), e1 = eff1();
      if (e0) m_regs[wr0_addr] = wr0_data;
      if (e1) m_regs[wr1_addr] = wr1_data;
      if (e0 && e1 && wr0_addr == wr1_addr) m_cnt = m_cnt + 1;
      else m_cnt = m_cnt + 32'(e0) + 32'(e1);
      if (e0) m_busy[wr0_addr] = 0;
      if (e1) m_busy[wr1_addr] = 0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rd_addr = '0; Reset = 1; step();
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; step();
    idle(); set_rd(0, 5); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL reset_pre_write got %h want deadbeef", rd_data[31:0]); end
    Reset = 1; step(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
      $display("FAIL reset_r5 got %h want 0", rd_data[31:0]); end
    checks++; if (rd_busy !== 2'b00) begin errors++;
      $display("FAIL reset_busy got %b want 00", rd_busy); end
    checks++; if (wr_count !== 32'd0) begin errors++;
      $display("FAIL reset_count got %0d want 0", wr_count); end
  endtask

  task automatic test_write_read();
    idle(); wr0_en = 1; wr0_addr = 3; wr0_data = 32'h12345678; step();
    idle(); set_rd(0, 3); #1;
    checks++; if (rd_data[31:0] !== 32'h12345678) begin errors++;
      $display("FAIL wr_read_r3 got %h want 12345678", rd_data[31:0]); end
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; set_rd(0, 0); #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
      $display("FAIL r0_bypass got %h want 0", rd_data[31:0]); end
    step(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++;
      $display("FAIL r0_read got %h want 0", rd_data[31:0]); end
    checks++; if (wr_count !== 32'd1) begin errors++;
      $display("FAIL r0_count got %0d want 1", wr_count); end
  endtask

  task automatic test_bypass();
    idle(); wr1_en = 1; wr1_addr = 7; wr1_data = 32'hA5A5A5A5; set_rd(1, 7); #1;
    checks++; if (rd_data[63:32] !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL bypass_p1 got %h want a5a5a5a5", rd_data[63:32]); end
    step(); idle(); #1;
    checks++; if (rd_data[63:32] !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL bypass_stored got %h want a5a5a5a5", rd_data[63:32]); end
    checks++; if (wr_count !== 32'd2) begin errors++;
      $display("FAIL bypass_count got %0d want 2", wr_count); end
  endtask

  task automatic test_collision();
    idle();
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h1111;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h2222; step();
    idle(); set_rd(0, 9); #1;
    checks++; if (rd_data[31:0] !== 32'h2222) begin errors++;
      $display("FAIL collide_data got %h want 2222", rd_data[31:0]); end
    checks++; if (wr_count !== 32'd3) begin errors++;
      $display("FAIL collide_count got %0d want 3", wr_count); end
    wr0_en = 1; wr0_addr = 9;  wr0_data = 32'hAAAA;
    wr1_en = 1; wr1_addr = 10; wr1_data = 32'hBBBB; step();
    idle(); set_rd(1, 10); #1;
    checks++; if (rd_data !== {32'hBBBB, 32'hAAAA}) begin errors++;
      $display("FAIL dual_write got %h want 0000bbbb0000aaaa", rd_data); end
    checks++; if (wr_count !== 32'd5) begin errors++;
      $display("FAIL dual_count got %0d want 5", wr_count); end
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1; iss_addr = 4; step();
    idle(); set_rd(0, 4); set_rd(1, 5); #1;
    checks++; if (rd_busy !== 2'b01) begin errors++;
      $display("FAIL sb_set got %b want 01", rd_busy); end
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h55; #1;
    checks++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55) begin errors++;
      $display("FAIL sb_clear_bypass got busy=%b data=%h want 0/55", rd_busy[0], rd_data[31:0]); end
    step(); idle(); #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++;
      $display("FAIL sb_cleared got %b want 0", rd_busy[0]); end
    iss_en = 1; iss_addr = 4; wr0_en = 1; wr0_addr = 4; wr0_data = 32'h66; step();
    idle(); #1;
    checks++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h66) begin errors++;
      $display("FAIL sb_issue_wins got busy=%b data=%h want 1/66", rd_busy[0], rd_data[31:0]); end
    iss_en = 1; iss_addr = 0; step(); idle(); set_rd(0, 0); #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++;
      $display("FAIL sb_r0 got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_reset_mid();
    idle(); Reset = 1; iss_en = 1; iss_addr = 6;
    wr0_en = 1; wr0_addr = 6; wr0_data = 32'h77; step();
    idle(); set_rd(0, 6); #1;
    checks++; if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin errors++;
      $display("FAIL reset_mid got data=%h busy=%b want 0/0", rd_data[31:0], rd_busy[0]); end
    checks++; if (wr_count !== 32'd0) begin errors++;
      $display("FAIL reset_mid_count got %0d want 0", wr_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Reset    = ($urandom_range(0, 63) == 0);
      wr0_en   = $urandom_range(0, 1) == 1;
      wr1_en   = $urandom_range(0, 1) == 1;
      iss_en   = $urandom_range(0, 1) == 1;
      wr0_addr = AW'($urandom_range(0, 7));
      wr1_addr = AW'($urandom_range(0, 7));
      iss_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom; wr1_data = $urandom;
      for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, 7));
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++; if (rd_data[k*DW +: DW] !== exp_data(k) || rd_busy[k] !== exp_busy(k)) begin
          errors++;
          $display("FAIL rand_port%0d iter %0d got %h/%b want %h/%b", k, n,
                   rd_data[k*DW +: DW], rd_busy[k], exp_data(k), exp_busy(k));
        end
      end
      checks++; if (wr_count !== m_cnt) begin errors++;
        $display("FAIL rand_count iter %0d got %0d want %0d", n, wr_count, m_cnt); end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
Parametrised successor to the single-write general-purpose register file in the pipelined CPU.
- Provides NUM_RD combinational read ports and two write ports: WB0 for ALU/load and WB1 for a second retire lane or a late multiply/divide result.
- Includes same-cycle write-to-read bypass.
- Includes a per-register pending-write scoreboard, which the decode stage uses to detect RAW hazards without a separate hazard table.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1, index 0 reads 0, ignores writes and is never busy

Ports:
clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous active-high reset, sampled on rising edge of clk
rd_addr  input  NUM_RD*ADDR_W  packed read indices; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_busy  output  NUM_RD  port k's register has an outstanding pending write, combinational
wr0_en  input  1  write enable, lane 0
wr0_addr  input  ADDR_W  write index, lane 0
wr0_data  input  DATA_W  write data, lane 0
wr1_en  input  1  write enable, lane 1
wr1_addr  input  ADDR_W  write index, lane 1
wr1_data  input  DATA_W  write data, lane 1
iss_en  input  1  an instruction issuing this cycle will write iss_addr
iss_addr  input  ADDR_W  destination index of the issuing instruction
wr_count  output  32  number of committed register writes since reset

Behaviour:
- Reset: one clock with Reset=1 clears all registers to 0, all busy bits to 0 and wr_count to 0. Reset overrides all writes and issues in that cycle. Combinational outputs after reset: rd_data=0, rd_busy=0.
- Storage: array of 2**ADDR_W x DATA_W flops. Writes commit on the rising edge, so latency is 1 cycle.
- Write qualification: a lane is effective when wrX_en=1, and additionally wrX_addr!=0 if ZERO_REG=1.
- Write collision: if both lanes are effective to the same index, lane 1 wins. wr_count increments by 1 only for that collision.
- wr_count: otherwise increments by the number of effective lanes (0, 1 or 2). Wraps modulo 2**32.
- Read path, per port k, priority order:
  1. if ZERO_REG and rd_addr_k==0, then 0;
  2. else if lane 1 is effective to rd_addr_k, then wr1_data;
  3. else if lane 0 is effective to rd_addr_k, then wr0_data;
  4. else the stored value.
  The bypass is purely combinational, so a read in the same cycle as a write returns the new data.
- Scoreboard, one busy bit per index, next-state on the edge:
  - set when iss_en and iss_addr is effective (nonzero if ZERO_REG);
  - cleared when an effective write lane targets the index;
  - same-cycle issue and write to the same index leaves busy=1, because the issue is the younger producer.
  - Busy bit 0 is forced to 0 when ZERO_REG=1.
- rd_busy_k = busy[rd_addr_k] AND NOT (an effective write to rd_addr_k this cycle). The clearing write is bypassed, so it produces no stall.
- No error flagging for a write to a non-busy register: the write commits and busy stays 0.
- Each effective write emits the simulation-only trace $display("@%0t: $%0d <= %h", ...).

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert Reset for 1 cycle, then read r5 -> 0; rd_busy=0; wr_count=0.
- Write/read and zero register: wr0 r3<=0x12345678, next cycle read r3 on port 0 -> 0x12345678. wr0 r0<=0xFFFFFFFF, then read r0 -> 0 and wr_count unchanged.
- Bypass: in the same cycle wr1 r7<=0xA5A5A5A5 and port 1 reads r7 -> rd_data port1 = 0xA5A5A5A5 combinationally. Stored value equals it after the edge.
- Collision: wr0 r9<=0x1111 and wr1 r9<=0x2222 in one cycle -> read r9 = 0x2222; wr_count +1. Separate indices r9 and r10 -> wr_count +2.
- Scoreboard: iss r4, next cycle read r4 -> rd_busy=1. Cycle with wr0 r4<=0x55 -> rd_busy=0 and rd_data=0x55. iss r4 and wr0 r4 in the same cycle -> next cycle rd_busy=1.
- Reset mid-operation: iss r6 and wr0 r6<=0x77 in the same cycle as Reset=1 -> afterwards r6=0, busy=0, wr_count=0.
